modinv_helper_update_engine: RTL and testbench

Word-serial update engine for one iteration of the binary extended-Euclid modular inverter. It streams the precomputed helper results (doubled, halved, summed, halved-difference) from the helper buffers back into the r/s/u/v working buffers. It generalises the fixed 32-bit, 9-word, one-cycle-read update helper in three ways: word width, buffer depth and buffer read latency are all parameters. It also latches the branch decision at start, reports the branch taken, supports abort, and emits a done pulse.

---
 rtl/modinv_helper_pkg.sv | 33 +++
 rtl/modinv_helper_addr_seq.sv | 57 +++++
 rtl/modinv_helper_update_engine.sv | 142 ++++++++++++++
 tb/tb_modinv_helper_update_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/modinv_helper_pkg.sv
// Shared definitions for the modular-inverse helper stages: branch encoding,
// latency limits and small elaboration-time helpers.
package modinv_helper_pkg;

  typedef enum logic [2:0] {
    OP_U_EVEN = 3'd0,
    OP_V_EVEN = 3'd1,
    OP_U_GT_V = 3'd2,
    OP_V_GE_U = 3'd3,
    OP_SKIP   = 3'd4
  } op_e;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 3;

  // Number of bits needed to index 'value' distinct states.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits = bits + 1;
    return bits;
  endfunction

  function automatic op_e decode_op(input logic v_eq_1, input logic u_is_even,
                                    input logic v_is_even, input logic u_gt_v);
    if (v_eq_1)    return OP_SKIP;
    if (u_is_even) return OP_U_EVEN;
    if (v_is_even) return OP_V_EVEN;
    if (u_gt_v)    return OP_U_GT_V;
    return OP_V_GE_U;
  endfunction

endpackage

// File: rtl/modinv_helper_addr_seq.sv
// Pass counter for word-serial helper stages: produces the read address, the
// latency-delayed write address/window and the final-cycle flag.
module modinv_helper_addr_seq
  import modinv_helper_pkg::*;
#(
  parameter int NUM_WORDS    = 9,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_BITS    = 4,
  parameter int CNT_BITS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  output logic [CNT_BITS-1:0]  cnt,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic                 wr_window,
  output logic                 last
);

  localparam logic [CNT_BITS-1:0] ONE      = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] RD_LAST  = CNT_BITS'(NUM_WORDS);
  localparam logic [CNT_BITS-1:0] WR_FIRST = CNT_BITS'(READ_LATENCY + 1);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(NUM_WORDS + READ_LATENCY);

  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == '0) begin
      if (start) cnt_d = ONE;
    end else if (clear || cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Writes trail reads by the buffer latency so each write sees its own word.
  always_comb begin
    rd_addr   = '0;
    wr_addr   = '0;
    wr_window = (cnt_q >= WR_FIRST) && (cnt_q <= LAST_CNT);
    if (cnt_q != '0 && cnt_q <= RD_LAST) rd_addr = ADDR_BITS'(cnt_q - ONE);
    if (wr_window) wr_addr = ADDR_BITS'(cnt_q - WR_FIRST);
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == LAST_CNT);

endmodule

// File: rtl/modinv_helper_update_engine.sv
// One binary extended-Euclid update step: streams the precomputed helper words
// back into the r/s/u/v buffers for the branch chosen at start.
module modinv_helper_update_engine
  import modinv_helper_pkg::*;
#(
  parameter int WORD_WIDTH       = 32,
  parameter int BUFFER_NUM_WORDS = 9,
  parameter int BUFFER_ADDR_BITS = 4,
  parameter int READ_LATENCY     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        abort,
  output logic                        rdy,
  output logic                        done,
  output logic [2:0]                  op,
  input  logic                        u_gt_v,
  input  logic                        v_eq_1,
  input  logic                        u_is_even,
  input  logic                        v_is_even,
  output logic [BUFFER_ADDR_BITS-1:0] r_addr,
  output logic [BUFFER_ADDR_BITS-1:0] s_addr,
  output logic [BUFFER_ADDR_BITS-1:0] u_addr,
  output logic [BUFFER_ADDR_BITS-1:0] v_addr,
  output logic                        r_wren,
  output logic                        s_wren,
  output logic                        u_wren,
  output logic                        v_wren,
  output logic [WORD_WIDTH-1:0]       r_dout,
  output logic [WORD_WIDTH-1:0]       s_dout,
  output logic [WORD_WIDTH-1:0]       u_dout,
  output logic [WORD_WIDTH-1:0]       v_dout,
  output logic [BUFFER_ADDR_BITS-1:0] r_dbl_addr,
  output logic [BUFFER_ADDR_BITS-1:0] s_dbl_addr,
  output logic [BUFFER_ADDR_BITS-1:0] r_plus_s_addr,
  output logic [BUFFER_ADDR_BITS-1:0] u_half_addr,
  output logic [BUFFER_ADDR_BITS-1:0] v_half_addr,
  output logic [BUFFER_ADDR_BITS-1:0] u_minus_v_half_addr,
  output logic [BUFFER_ADDR_BITS-1:0] v_minus_u_half_addr,
  input  logic [WORD_WIDTH-1:0]       r_dbl_din,
  input  logic [WORD_WIDTH-1:0]       s_dbl_din,
  input  logic [WORD_WIDTH-1:0]       r_plus_s_din,
  input  logic [WORD_WIDTH-1:0]       u_half_din,
  input  logic [WORD_WIDTH-1:0]       v_half_din,
  input  logic [WORD_WIDTH-1:0]       u_minus_v_half_din,
  input  logic [WORD_WIDTH-1:0]       v_minus_u_half_din
);

  // Out-of-range latencies are pinned to the nearest supported value.
  localparam int LAT = (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
                       (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY;
  localparam int CNT_RAW  = clog2(BUFFER_NUM_WORDS + LAT + 1);
  localparam int CNT_BITS = (CNT_RAW > BUFFER_ADDR_BITS) ? CNT_RAW : BUFFER_ADDR_BITS;

  logic [CNT_BITS-1:0]         cnt;
  logic [BUFFER_ADDR_BITS-1:0] rd_addr, wr_addr;
  logic                        wr_window, last, busy, start, clear, wr_go;
  op_e                         op_q, op_d;

  assign busy  = (cnt != '0);
  assign start = ena && !abort;
  assign clear = busy && (abort || op_q == OP_SKIP);

  modinv_helper_addr_seq #(
    .NUM_WORDS   (BUFFER_NUM_WORDS),
    .READ_LATENCY(LAT),
    .ADDR_BITS   (BUFFER_ADDR_BITS),
    .CNT_BITS    (CNT_BITS)
  ) u_addr_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .clear    (clear),
    .cnt      (cnt),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr),
    .wr_window(wr_window),
    .last     (last)
  );

  // Flags are only trusted at the start edge; the branch is frozen for the pass.
  always_comb begin
    op_d = op_q;
    if (!busy && start) op_d = decode_op(v_eq_1, u_is_even, v_is_even, u_gt_v);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_q <= OP_U_EVEN;
    else     op_q <= op_d;
  end

  assign rdy   = !busy;
  assign op    = op_q;
  assign done  = busy && !abort && (op_q == OP_SKIP || last);
  assign wr_go = wr_window && !abort;

  always_comb begin
    r_wren = 1'b0;
    s_wren = 1'b0;
    u_wren = 1'b0;
    v_wren = 1'b0;
    r_dout = '0;
    s_dout = '0;
    u_dout = '0;
    v_dout = '0;
    case (op_q)
      OP_U_EVEN: begin
        u_wren = wr_go;  u_dout = u_half_din;
        s_wren = wr_go;  s_dout = s_dbl_din;
      end
      OP_V_EVEN: begin
        v_wren = wr_go;  v_dout = v_half_din;
        r_wren = wr_go;  r_dout = r_dbl_din;
      end
      OP_U_GT_V: begin
        u_wren = wr_go;  u_dout = u_minus_v_half_din;
        r_wren = wr_go;  r_dout = r_plus_s_din;
        s_wren = wr_go;  s_dout = s_dbl_din;
      end
      OP_V_GE_U: begin
        v_wren = wr_go;  v_dout = v_minus_u_half_din;
        s_wren = wr_go;  s_dout = r_plus_s_din;
        r_wren = wr_go;  r_dout = r_dbl_din;
      end
      default: ;
    endcase
  end

  assign r_addr              = wr_addr;
  assign s_addr              = wr_addr;
  assign u_addr              = wr_addr;
  assign v_addr              = wr_addr;
  assign r_dbl_addr          = rd_addr;
  assign s_dbl_addr          = rd_addr;
  assign r_plus_s_addr       = rd_addr;
  assign u_half_addr         = rd_addr;
  assign v_half_addr         = rd_addr;
  assign u_minus_v_half_addr = rd_addr;
  assign v_minus_u_half_addr = rd_addr;

endmodule

// File: tb/tb_modinv_helper_update_engine.sv
// Scoreboard bench for the helper update engine: 64-bit words, six-word
// buffers and a three-cycle helper read latency.
module tb_modinv_helper_update_engine;
  import modinv_helper_pkg::*;

  localparam int W  = 64;
  localparam int N  = 6;
  localparam int L  = 3;
  localparam int AW = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ena = 1'b0, abort = 1'b0;
  logic u_gt_v = 1'b0, v_eq_1 = 1'b0, u_is_even = 1'b0, v_is_even = 1'b0;
  logic rdy, done;
  logic [2:0] op;
  logic [AW-1:0] r_addr, s_addr, u_addr, v_addr;
  logic r_wren, s_wren, u_wren, v_wren;
  logic [W-1:0] r_dout, s_dout, u_dout, v_dout;
  logic [AW-1:0] rd_a [7];
  logic [W-1:0]  din [7];
  logic [AW-1:0] pipe [7][L];

  int   epoch = 0;
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;
  wr_t  q_wr [4][$];
  logic [2:0] q_dn [$];

  always #5 clk = ~clk;

  modinv_helper_update_engine #(
    .WORD_WIDTH(W), .BUFFER_NUM_WORDS(N), .BUFFER_ADDR_BITS(AW), .READ_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .abort(abort), .rdy(rdy), .done(done), .op(op),
    .u_gt_v(u_gt_v), .v_eq_1(v_eq_1), .u_is_even(u_is_even), .v_is_even(v_is_even),
    .r_addr(r_addr), .s_addr(s_addr), .u_addr(u_addr), .v_addr(v_addr),
    .r_wren(r_wren), .s_wren(s_wren), .u_wren(u_wren), .v_wren(v_wren),
    .r_dout(r_dout), .s_dout(s_dout), .u_dout(u_dout), .v_dout(v_dout),
    .r_dbl_addr(rd_a[0]), .s_dbl_addr(rd_a[1]), .r_plus_s_addr(rd_a[2]),
    .u_half_addr(rd_a[3]), .v_half_addr(rd_a[4]),
    .u_minus_v_half_addr(rd_a[5]), .v_minus_u_half_addr(rd_a[6]),
    .r_dbl_din(din[0]), .s_dbl_din(din[1]), .r_plus_s_din(din[2]),
    .u_half_din(din[3]), .v_half_din(din[4]),
    .u_minus_v_half_din(din[5]), .v_minus_u_half_din(din[6])
  );

  // Helper buffer contents: unique per buffer, word and pass.
  function automatic logic [W-1:0] pat(input int id, input logic [AW-1:0] a, input int ep);
    return {4'hA, 4'(id), 8'(a), 16'(ep), 32'h5A5A_0F0F ^ 32'(id * 7 + int'(a) * 13)};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 7; k++) begin
      pipe[k][0] <= rd_a[k];
      for (int j = 1; j < L; j++) pipe[k][j] <= pipe[k][j-1];
    end
  end

  always_comb begin
    for (int k = 0; k < 7; k++) din[k] = pat(k, pipe[k][L-1], epoch);
  end

  function automatic logic [2:0] model_op(input logic veq1, input logic ueven,
                                          input logic veven, input logic ugtv);
    logic [2:0] r;
    if (veq1)       r = 3'd4;
    else if (ueven) r = 3'd0;
    else if (veven) r = 3'd1;
    else if (ugtv)  r = 3'd2;
    else            r = 3'd3;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkWrite(input int k, input string name, input logic wren,
                            input logic [AW-1:0] addr, input logic [W-1:0] dout);
    wr_t e;
    if (wren) begin
      if (q_wr[k].size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s_write: actual=write at addr %0d required=no write", name, addr);
      end else begin
        e = q_wr[k].pop_front();
        checkOutput({name, "_addr"}, W'(addr), W'(e.addr));
        checkOutput({name, "_data"}, dout, e.data);
      end
    end
  endtask

  // Queue the writes one pass should make; words whose write cycle falls at or
  // after stop_at are cut off by an abort or reset.
  task automatic pushPass(input logic [2:0] o, input int stop_at, input bit expect_done);
    for (int a = 0; a < N; a++) begin
      if (o != 3'd4 && a + 1 + L < stop_at) begin
        case (o)
          3'd0: begin
            q_wr[2].push_back({AW'(a), pat(3, AW'(a), epoch)});
            q_wr[1].push_back({AW'(a), pat(1, AW'(a), epoch)});
          end
          3'd1: begin
            q_wr[3].push_back({AW'(a), pat(4, AW'(a), epoch)});
            q_wr[0].push_back({AW'(a), pat(0, AW'(a), epoch)});
          end
          3'd2: begin
            q_wr[2].push_back({AW'(a), pat(5, AW'(a), epoch)});
            q_wr[0].push_back({AW'(a), pat(2, AW'(a), epoch)});
            q_wr[1].push_back({AW'(a), pat(1, AW'(a), epoch)});
          end
          default: begin
            q_wr[3].push_back({AW'(a), pat(6, AW'(a), epoch)});
            q_wr[1].push_back({AW'(a), pat(2, AW'(a), epoch)});
            q_wr[0].push_back({AW'(a), pat(0, AW'(a), epoch)});
          end
        endcase
      end
    end
    if (expect_done) q_dn.push_back(o);
  endtask

  function automatic int pending();
    return q_wr[0].size() + q_wr[1].size() + q_wr[2].size() + q_wr[3].size() + q_dn.size();
  endfunction

  // Runs one pass; abort_at / rst_at (0 = never) interrupt it at that cnt value.
  task automatic applyStimulus(input logic veq1, input logic ueven, input logic veven,
                               input logic ugtv, input int abort_at, input int rst_at);
    logic [2:0] eo;
    int plen, stop_at;
    bit cut;
    eo      = model_op(veq1, ueven, veven, ugtv);
    plen    = (eo == 3'd4) ? 1 : N + L;
    stop_at = (abort_at > 0) ? abort_at : (rst_at > 0) ? rst_at : plen + 1;
    cut     = 1'b0;
    pushPass(eo, stop_at, abort_at == 0 && rst_at == 0);
    {v_eq_1, u_is_even, v_is_even, u_gt_v} = {veq1, ueven, veven, ugtv};
    ena = 1'b1;
    busy_cnt = 0;
    @(posedge clk); #1;
    ena = 1'b0;
    for (int c = 1; c <= plen; c++) begin
      checkOutput("rdy_busy", W'(rdy), W'(1'b0));
      checkOutput("op_latched", W'(op), W'(eo));
      if (c == abort_at) begin
        abort = 1'b1;
        #1;
        checkOutput("abort_quiet", W'({r_wren, s_wren, u_wren, v_wren, done}), W'(0));
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_rdy", W'(rdy), W'(1'b1));
        cut = 1'b1;
        break;
      end
      if (c == rst_at) begin
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_quiet", W'({r_wren, s_wren, u_wren, v_wren, done}), W'(0));
        checkOutput("rst_addrs", W'({r_addr, s_addr, u_addr, v_addr, rd_a[0], rd_a[1],
                                      rd_a[2], rd_a[3], rd_a[4], rd_a[5], rd_a[6]}), W'(0));
        checkOutput("rst_rdy", W'(rdy), W'(1'b1));
        #1 rst = 1'b0;
        cut = 1'b1;
        break;
      end
      checkOutput("done_timing", W'(done), W'(c == plen));
      {v_eq_1, u_is_even, v_is_even, u_gt_v} = 4'($urandom);
      @(posedge clk); #1;
    end
    if (!cut) begin
      checkOutput("rdy_after", W'(rdy), W'(1'b1));
      checkOutput("busy_cycles", W'(busy_cnt), W'(plen));
    end
    checkOutput("pending_expect", W'(pending()), W'(0));
  endtask

  task automatic runBackToBack();
    int nd;
    nd = 0;
    pushPass(3'd1, N + L + 1, 1'b1);
    pushPass(3'd1, N + L + 1, 1'b1);
    {v_eq_1, u_is_even, v_is_even, u_gt_v} = 4'b0010;
    ena = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 4 * (N + L) && nd < 2; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    ena = 1'b0;
    checkOutput("b2b_done_count", W'(nd), W'(2));
    @(posedge clk); #1;
    checkOutput("b2b_rdy", W'(rdy), W'(1'b1));
    checkOutput("b2b_busy_cycles", W'(busy_cnt), W'(2 * (N + L)));
    checkOutput("b2b_pending", W'(pending()), W'(0));
  endtask

  always @(negedge clk) begin : monitor
    logic [2:0] e;
    if (!rst) begin
      if (!rdy) busy_cnt++;
      checkWrite(0, "r", r_wren, r_addr, r_dout);
      checkWrite(1, "s", s_wren, s_addr, s_dout);
      checkWrite(2, "u", u_wren, u_addr, u_dout);
      checkWrite(3, "v", v_wren, v_addr, v_dout);
      if (done) begin
        if (q_dn.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL done_pulse: actual=done with op %0d required=no done", op);
        end else begin
          e = q_dn.pop_front();
          checkOutput("done_op", W'(op), W'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    #11;
    checkOutput("reset_rdy", W'(rdy), W'(1'b1));
    checkOutput("reset_op", W'(op), W'(0));
    checkOutput("reset_quiet", W'({r_wren, s_wren, u_wren, v_wren, done}), W'(0));
    checkOutput("reset_addrs", W'({r_addr, s_addr, u_addr, v_addr, rd_a[0], rd_a[3], rd_a[6]}), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    epoch = 1;  applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    epoch = 2;  applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    epoch = 3;  applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    epoch = 4;  applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    epoch = 5;  applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
    epoch = 6;  applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5, 0);
    epoch = 7;  applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    {v_eq_1, u_is_even, v_is_even, u_gt_v} = 4'b0100;
    ena = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_abort_rdy", W'(rdy), W'(1'b1));
    ena = 1'b0;
    abort = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_abort_stay", W'(rdy), W'(1'b1));

    epoch = 8;  runBackToBack();
    epoch = 9;  applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 6);
    epoch = 10; applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("final_pending", W'(pending()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
